alu_decode_stage: RTL and testbench

Registered decode stage directly upstream of the 32-bit ALU. Accepts a MIPS instruction word with its two register-file read values, derives the 4-bit `aluc` opcode and the `a`/`b` operands in the ALU's conventions, and presents them through a valid/ready register slice. The ALU consumes `out_aluc`, `out_a` and `out_b` combinationally. It is one stage of the execute pipeline; backpressure comes from the result writeback stage.

---
 rtl/alu_pkg.sv | 60 ++++++
 rtl/alu_inst_decode.sv | 133 +++++++++++++
 rtl/alu_decode_stage.sv | 123 ++++++++++++
 tb/tb_alu_decode_stage.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared encodings and the decoded micro-op for the ALU decode stage.
// The ALU_DECODE_SKID_EN build option is consumed by alu_decode_stage, not here.
package alu_pkg;

   localparam logic [3:0] ALUC_ADDU = 4'b0000;
   localparam logic [3:0] ALUC_SUBU = 4'b0001;
   localparam logic [3:0] ALUC_ADD  = 4'b0010;
   localparam logic [3:0] ALUC_SUB  = 4'b0011;
   localparam logic [3:0] ALUC_AND  = 4'b0100;
   localparam logic [3:0] ALUC_OR   = 4'b0101;
   localparam logic [3:0] ALUC_XOR  = 4'b0110;
   localparam logic [3:0] ALUC_NOR  = 4'b0111;
   localparam logic [3:0] ALUC_LUI  = 4'b1000;
   localparam logic [3:0] ALUC_SLTU = 4'b1010;
   localparam logic [3:0] ALUC_SLT  = 4'b1011;
   localparam logic [3:0] ALUC_SRA  = 4'b1100;
   localparam logic [3:0] ALUC_SRL  = 4'b1101;
   localparam logic [3:0] ALUC_SLL  = 4'b1110;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ADDIU = 6'b001001;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] OP_SLTIU = 6'b001011;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_XORI  = 6'b001110;
   localparam logic [5:0] OP_LUI   = 6'b001111;

   localparam logic [5:0] FN_SLL  = 6'b000000;
   localparam logic [5:0] FN_SRL  = 6'b000010;
   localparam logic [5:0] FN_SRA  = 6'b000011;
   localparam logic [5:0] FN_SLLV = 6'b000100;
   localparam logic [5:0] FN_SRLV = 6'b000110;
   localparam logic [5:0] FN_SRAV = 6'b000111;
   localparam logic [5:0] FN_ADD  = 6'b100000;
   localparam logic [5:0] FN_ADDU = 6'b100001;
   localparam logic [5:0] FN_SUB  = 6'b100010;
   localparam logic [5:0] FN_SUBU = 6'b100011;
   localparam logic [5:0] FN_AND  = 6'b100100;
   localparam logic [5:0] FN_OR   = 6'b100101;
   localparam logic [5:0] FN_XOR  = 6'b100110;
   localparam logic [5:0] FN_NOR  = 6'b100111;
   localparam logic [5:0] FN_SLT  = 6'b101010;
   localparam logic [5:0] FN_SLTU = 6'b101011;

   typedef struct packed {
      logic [3:0]  aluc;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  dst;
      logic        wen;
      logic        illegal;
   } alu_uop_t;

   function automatic logic [31:0] sext16(input logic [15:0] imm);
      return {{16{imm[15]}}, imm};
   endfunction

endpackage

// File: rtl/alu_inst_decode.sv
// Combinational MIPS instruction to ALU micro-op mapping.
// Shift amounts travel in operand a, the shifted value in operand b.
module alu_inst_decode
   import alu_pkg::*;
(
   input  logic [31:0] inst,
   input  logic [31:0] rs,
   input  logic [31:0] rt,
   output alu_uop_t    uop
);

   logic [5:0]  opcode;
   logic [5:0]  funct;
   logic [4:0]  rt_idx;
   logic [4:0]  rd_idx;
   logic [4:0]  shamt;
   logic [15:0] imm;

   logic        legal;
   logic [3:0]  aluc;
   logic [31:0] op_a;
   logic [31:0] op_b;
   logic [4:0]  dst;

   // The rs register index is already resolved into the rs value by the register file.
   logic unused_rs_idx;
   assign unused_rs_idx = ^inst[25:21];

   assign opcode = inst[31:26];
   assign rt_idx = inst[20:16];
   assign rd_idx = inst[15:11];
   assign shamt  = inst[10:6];
   assign funct  = inst[5:0];
   assign imm    = inst[15:0];

   always_comb begin
      legal = 1'b1;
      aluc  = ALUC_ADDU;
      op_a  = rs;
      op_b  = rt;
      dst   = rd_idx;
      if (opcode == OP_RTYPE) begin
         case (funct)
            FN_ADD:  aluc = ALUC_ADD;
            FN_ADDU: aluc = ALUC_ADDU;
            FN_SUB:  aluc = ALUC_SUB;
            FN_SUBU: aluc = ALUC_SUBU;
            FN_AND:  aluc = ALUC_AND;
            FN_OR:   aluc = ALUC_OR;
            FN_XOR:  aluc = ALUC_XOR;
            FN_NOR:  aluc = ALUC_NOR;
            FN_SLT:  aluc = ALUC_SLT;
            FN_SLTU: aluc = ALUC_SLTU;
            FN_SLL: begin
               aluc = ALUC_SLL;
               op_a = {27'b0, shamt};
            end
            FN_SRL: begin
               aluc = ALUC_SRL;
               op_a = {27'b0, shamt};
            end
            FN_SRA: begin
               aluc = ALUC_SRA;
               op_a = {27'b0, shamt};
            end
            FN_SLLV: begin
               aluc = ALUC_SLL;
               op_a = {27'b0, rs[4:0]};
            end
            FN_SRLV: begin
               aluc = ALUC_SRL;
               op_a = {27'b0, rs[4:0]};
            end
            FN_SRAV: begin
               aluc = ALUC_SRA;
               op_a = {27'b0, rs[4:0]};
            end
            default: legal = 1'b0;
         endcase
      end else begin
         dst = rt_idx;
         case (opcode)
            OP_ADDI: begin
               aluc = ALUC_ADD;
               op_b = sext16(imm);
            end
            OP_ADDIU: begin
               aluc = ALUC_ADDU;
               op_b = sext16(imm);
            end
            OP_SLTI: begin
               aluc = ALUC_SLT;
               op_b = sext16(imm);
            end
            OP_SLTIU: begin
               aluc = ALUC_SLTU;
               op_b = sext16(imm);
            end
            OP_ANDI: begin
               aluc = ALUC_AND;
               op_b = {16'b0, imm};
            end
            OP_ORI: begin
               aluc = ALUC_OR;
               op_b = {16'b0, imm};
            end
            OP_XORI: begin
               aluc = ALUC_XOR;
               op_b = {16'b0, imm};
            end
            // The ALU itself moves the immediate into the upper half.
            OP_LUI: begin
               aluc = ALUC_LUI;
               op_a = '0;
               op_b = {16'b0, imm};
            end
            default: legal = 1'b0;
         endcase
      end

      uop         = '0;
      uop.illegal = 1'b1;
      if (legal) begin
         uop.aluc    = aluc;
         uop.a       = op_a;
         uop.b       = op_b;
         uop.dst     = dst;
         uop.wen     = (dst != 5'd0);
         uop.illegal = 1'b0;
      end
   end

endmodule

// File: rtl/alu_decode_stage.sv
// Registered decode stage in front of the ALU: decoder plus valid/ready output slice.
// Define ALU_DECODE_SKID_EN to add a skid entry so in_ready comes straight from a flop.
module alu_decode_stage
   import alu_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_inst,
   input  logic [31:0] in_rs,
   input  logic [31:0] in_rt,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [3:0]  out_aluc,
   output logic [31:0] out_a,
   output logic [31:0] out_b,
   output logic [4:0]  out_dst,
   output logic        out_wen,
   output logic        out_illegal
);

   // Handshake: a beat moves on a rising edge where valid && ready; payload holds while valid && !ready.

   alu_uop_t dec_uop;
   alu_uop_t out_q;
   alu_uop_t out_d;
   logic     out_valid_q;
   logic     out_valid_d;
   logic     push;

   alu_inst_decode u_decode (
      .inst (in_inst),
      .rs   (in_rs),
      .rt   (in_rt),
      .uop  (dec_uop)
   );

`ifdef ALU_DECODE_SKID_EN
   alu_uop_t skid_q;
   alu_uop_t skid_d;
   logic     skid_valid_q;
   logic     skid_valid_d;
   logic     in_ready_q;
   logic     in_ready_d;

   assign in_ready = in_ready_q;
   assign push     = in_valid && in_ready_q;

   always_comb begin
      out_d        = out_q;
      out_valid_d  = out_valid_q;
      skid_d       = skid_q;
      skid_valid_d = skid_valid_q;
      if (!out_valid_q || out_ready) begin
         // The skid entry is older than anything on the input, so it drains first.
         if (skid_valid_q) begin
            out_d        = skid_q;
            out_valid_d  = 1'b1;
            skid_valid_d = 1'b0;
         end else if (push) begin
            out_d       = dec_uop;
            out_valid_d = 1'b1;
         end else begin
            out_valid_d = 1'b0;
         end
      end else if (push) begin
         skid_d       = dec_uop;
         skid_valid_d = 1'b1;
      end
      in_ready_d = !skid_valid_d;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_q        <= '0;
         out_valid_q  <= 1'b0;
         skid_q       <= '0;
         skid_valid_q <= 1'b0;
         in_ready_q   <= 1'b1;
      end else begin
         out_q        <= out_d;
         out_valid_q  <= out_valid_d;
         skid_q       <= skid_d;
         skid_valid_q <= skid_valid_d;
         in_ready_q   <= in_ready_d;
      end
   end
`else
   assign in_ready = !out_valid_q || out_ready;
   assign push     = in_valid && in_ready;

   always_comb begin
      out_d       = out_q;
      out_valid_d = out_valid_q;
      if (push) begin
         out_d       = dec_uop;
         out_valid_d = 1'b1;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_q       <= '0;
         out_valid_q <= 1'b0;
      end else begin
         out_q       <= out_d;
         out_valid_q <= out_valid_d;
      end
   end
`endif

   assign out_valid   = out_valid_q;
   assign out_aluc    = out_q.aluc;
   assign out_a       = out_q.a;
   assign out_b       = out_q.b;
   assign out_dst     = out_q.dst;
   assign out_wen     = out_q.wen;
   assign out_illegal = out_q.illegal;

endmodule

// File: tb/tb_alu_decode_stage.sv
// Randomized bench for alu_decode_stage: table-driven decode model and an in-order scoreboard.
// Works with or without ALU_DECODE_SKID_EN defined.
module tb_alu_decode_stage;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_inst;
   logic [31:0] in_rs;
   logic [31:0] in_rt;
   logic        out_valid;
   logic        out_ready;
   logic [3:0]  out_aluc;
   logic [31:0] out_a;
   logic [31:0] out_b;
   logic [4:0]  out_dst;
   logic        out_wen;
   logic        out_illegal;

   alu_decode_stage dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_inst     (in_inst),
      .in_rs       (in_rs),
      .in_rt       (in_rt),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_aluc    (out_aluc),
      .out_a       (out_a),
      .out_b       (out_b),
      .out_dst     (out_dst),
      .out_wen     (out_wen),
      .out_illegal (out_illegal)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   localparam int ARITH_CODE[8] = '{2, 0, 3, 1, 4, 5, 6, 7};
   localparam int IMM_CODE[8]   = '{2, 0, 11, 10, 4, 5, 6, 8};
   localparam logic [5:0] R_FN[16] = '{6'd0, 6'd2, 6'd3, 6'd4, 6'd6, 6'd7, 6'd32, 6'd33,
                                       6'd34, 6'd35, 6'd36, 6'd37, 6'd38, 6'd39, 6'd42, 6'd43};

   // Result layout: {aluc[3:0], a[31:0], b[31:0], dst[4:0], wen, illegal}
   function automatic logic [74:0] model(input logic [31:0] inst, input logic [31:0] rs,
                                         input logic [31:0] rt);
      int          op;
      int          fn;
      int          code;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  d;
      logic [15:0] imm;
      op   = int'(inst[31:26]);
      fn   = int'(inst[5:0]);
      imm  = inst[15:0];
      code = -1;
      a    = rs;
      b    = rt;
      if (op == 0) begin
         d = inst[15:11];
         if (fn >= 32 && fn <= 39) code = ARITH_CODE[fn - 32];
         else if (fn == 42) code = 11;
         else if (fn == 43) code = 10;
         else if (fn < 8 && (fn % 4) != 1) begin
            code = (fn % 4 == 0) ? 14 : ((fn % 4 == 2) ? 13 : 12);
            a    = (fn < 4) ? 32'(inst[10:6]) : (rs % 32);
         end
      end else begin
         d = inst[20:16];
         if (op >= 8 && op <= 15) begin
            code = IMM_CODE[op - 8];
            if (op <= 11) b = 32'($signed(imm));
            else b = 32'(imm);
            if (op == 15) a = 32'd0;
         end
      end
      if (code < 0) return 75'd1;
      return {4'(code), a, b, d, (d != 5'd0), 1'b0};
   endfunction

   function automatic logic [31:0] rand_inst();
      logic [31:0] w;
      int          sel;
      w   = $urandom();
      sel = $urandom_range(0, 9);
      if (sel < 5) begin
         w[31:26] = 6'd0;
         w[5:0]   = R_FN[$urandom_range(0, 15)];
      end else if (sel < 9) begin
         w[31:26] = 6'($urandom_range(8, 15));
      end
      if ($urandom_range(0, 7) == 0) w[15:11] = 5'd0;
      if ($urandom_range(0, 7) == 0) w[20:16] = 5'd0;
      return w;
   endfunction

   // ---------------- scoreboard ----------------
   logic [74:0] exp_q[$];
   logic [31:0] src_inst[$];
   logic [31:0] src_rs[$];
   logic [31:0] src_rt[$];
   int          checks;
   int          failures;
   bit          pending;
   bit          hold_valid;
   logic [74:0] held;
   logic [74:0] payload;

   assign payload = {out_aluc, out_a, out_b, out_dst, out_wen, out_illegal};

   task automatic chk(input string name, input logic [74:0] act, input logic [74:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", name, act, exp);
      end
   endtask

   task automatic add_beat(input logic [31:0] inst, input logic [31:0] rs, input logic [31:0] rt);
      src_inst.push_back(inst);
      src_rs.push_back(rs);
      src_rt.push_back(rt);
   endtask

   // One clock: drive at negedge, sample 1 ns later (well before the rising edge).
   task automatic cycle(input bit ready, input bit offer);
      @(negedge clk);
      rst_n     = 1'b1;
      out_ready = ready;
      if (!pending) begin
         if (offer && src_inst.size() > 0) begin
            in_valid = 1'b1;
            in_inst  = src_inst[0];
            in_rs    = src_rs[0];
            in_rt    = src_rt[0];
         end else begin
            in_valid = 1'b0;
            in_inst  = $urandom();
         end
      end
      #1;
      if (hold_valid) begin
         chk("stall_valid", 75'(out_valid), 75'd1);
         chk("stall_payload", payload, held);
      end
      chk("out_valid_occupancy", 75'(out_valid), 75'(exp_q.size() != 0));
`ifdef ALU_DECODE_SKID_EN
      chk("in_ready_skid", 75'(in_ready), 75'(exp_q.size() < 2));
`else
      chk("in_ready_comb", 75'(in_ready), 75'(exp_q.size() == 0 || ready));
`endif
      if (out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_beat got=%h exp=none", payload);
         end else begin
            chk("beat_payload", payload, exp_q.pop_front());
         end
      end
      if (in_valid && in_ready) begin
         exp_q.push_back(model(in_inst, in_rs, in_rt));
         void'(src_inst.pop_front());
         void'(src_rs.pop_front());
         void'(src_rt.pop_front());
         pending = 1'b0;
      end else begin
         pending = in_valid;
      end
      hold_valid = out_valid && !out_ready;
      held       = payload;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("reset_out_valid", 75'(out_valid), 75'd0);
      chk("reset_in_ready", 75'(in_ready), 75'd1);
      chk("reset_payload", payload, 75'd0);
      exp_q.delete();
      src_inst.delete();
      src_rs.delete();
      src_rt.delete();
      pending    = 1'b0;
      hold_valid = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   initial begin
      checks     = 0;
      failures   = 0;
      pending    = 1'b0;
      hold_valid = 1'b0;
      held       = '0;
      rst_n      = 1'b0;
      in_valid   = 1'b0;
      in_inst    = '0;
      in_rs      = '0;
      in_rt      = '0;
      out_ready  = 1'b0;
      repeat (2) @(posedge clk);
      do_reset();

      // Hand-computed anchors for the model itself.
      chk("model_addi", model(32'h2109FFFF, 32'd5, 32'd0),
          {4'b0010, 32'd5, 32'hFFFFFFFF, 5'd9, 1'b1, 1'b0});
      chk("model_sra", model(32'h00021903, 32'd0, 32'h80000000),
          {4'b1100, 32'd4, 32'h80000000, 5'd3, 1'b1, 1'b0});
      chk("model_srav", model(32'h00432007, 32'h00000025, 32'hF0F0F0F0),
          {4'b1100, 32'd5, 32'hF0F0F0F0, 5'd4, 1'b1, 1'b0});
      chk("model_lui", model(32'h3C011234, 32'hDEADBEEF, 32'd0),
          {4'b1000, 32'd0, 32'h00001234, 5'd1, 1'b1, 1'b0});
      chk("model_illegal", model(32'hFC000000, 32'd7, 32'd9), 75'd1);
      chk("model_or_rd0", model(32'h00220025, 32'd6, 32'd3),
          {4'b0101, 32'd6, 32'd3, 5'd0, 1'b0, 1'b0});

      // Directed beats at full throughput.
      add_beat(32'h2109FFFF, 32'd5, 32'd0);
      add_beat(32'h00021903, 32'd0, 32'h80000000);
      add_beat(32'h00432007, 32'h00000025, 32'hF0F0F0F0);
      add_beat(32'h3C011234, 32'hDEADBEEF, 32'd0);
      add_beat(32'hFC000000, 32'd7, 32'd9);
      add_beat(32'h00220025, 32'd6, 32'd3);
      for (int i = 0; i < 8; i++) cycle(1'b1, 1'b1);
      chk("directed_drained", 75'(exp_q.size()), 75'd0);

      // Backpressure: four beats, output stalled for three cycles.
      for (int i = 0; i < 4; i++) add_beat(rand_inst(), $urandom(), $urandom());
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1);
`ifdef ALU_DECODE_SKID_EN
      chk("skid_full_in_ready", 75'(in_ready), 75'd0);
      chk("skid_full_count", 75'(exp_q.size()), 75'd2);
`endif
      for (int i = 0; i < 8; i++) cycle(1'b1, 1'b1);
      chk("backpressure_drained", 75'(exp_q.size() + src_inst.size()), 75'd0);

      // Reset while a beat is stalled.
      for (int i = 0; i < 3; i++) add_beat(rand_inst(), $urandom(), $urandom());
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1);
      do_reset();

      // Random traffic.
      for (int i = 0; i < 1500; i++) begin
         if (src_inst.size() < 2) add_beat(rand_inst(), $urandom(), $urandom());
         cycle($urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0);
      end

      for (int i = 0; i < 20 && (exp_q.size() != 0 || pending); i++) cycle(1'b1, 1'b0);
      chk("final_drained", 75'(exp_q.size()), 75'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
